// File: rtl/mdu_if.sv
// Execute-stage handshake between the issue logic and the iterative multiply/divide unit.
interface mdu_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [4:0]        dest_in;
    logic              kill;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [4:0]        dest_out;

    modport master (
        output start, op, operand_a, operand_b, dest_in, kill,
        input  busy, done, result, dest_out
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_in, kill,
        output busy, done, result, dest_out
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Result and destination feed the register-file write port; busy stalls the pipeline.
module mdu_iterative #(
    parameter int DATA_W = 16
) (
    input  logic  clk,
    input  logic  arst_n,
    mdu_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] opnd_q;
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [4:0]        dest_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic [4:0]        dest_out_q;

    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] trial;
    logic [DATA_W-1:0] hi_nxt;
    logic [DATA_W-1:0] lo_nxt;
    logic              unused_trial_bit;

    // Low-half ops read the lower accumulator (product low / quotient),
    // high-half ops the upper one (product high / remainder).
    function automatic logic [DATA_W-1:0] sel_result(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo
    );
        return op[0] ? hi : lo;
    endfunction

    // acc_hi:acc_lo is the product register for multiply and remainder:quotient for divide.
    // opnd_q holds the multiplicand or the divisor depending on the operation.
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        rem_sh  = {acc_hi, acc_lo[DATA_W-1]};
        trial   = {1'b0, rem_sh} - {2'b00, opnd_q};
        hi_nxt  = acc_hi;
        lo_nxt  = acc_lo;
        if (op_q[1]) begin
            if (!trial[DATA_W+1]) begin
                hi_nxt = trial[DATA_W-1:0];
                lo_nxt = {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                hi_nxt = rem_sh[DATA_W-1:0];
                lo_nxt = {acc_lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            hi_nxt = add_sum[DATA_W:1];
            lo_nxt = {add_sum[0], acc_lo[DATA_W-1:1]};
        end
    end

    // A kept trial difference is always below the divisor, so its bit DATA_W is zero.
    assign unused_trial_bit = trial[DATA_W];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            dest_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            dest_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.kill) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        op_q   <= bus.op;
                        opnd_q <= bus.op[1] ? bus.operand_b : bus.operand_a;
                        acc_hi <= '0;
                        acc_lo <= bus.op[1] ? bus.operand_a : bus.operand_b;
                        dest_q <= bus.dest_in;
                    end
                end
                RUN: begin
                    if (bus.kill) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc_hi <= hi_nxt;
                        acc_lo <= lo_nxt;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            result_q   <= sel_result(op_q, hi_nxt, lo_nxt);
                            dest_out_q <= dest_q;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.dest_out = dest_out_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases plus random back-to-back ops
// compared every cycle against a timeline/arithmetic model.
module tb_mdu_iterative;
    localparam int W = 16;

    logic clk;
    logic arst_n;
    int   checks;
    int   failures;

    mdu_if #(.DATA_W(W)) bus ();

    mdu_iterative #(.DATA_W(W)) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_calc(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == '0) ? {W{1'b1}} : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Model: age = cycles since acceptance (0 = idle), done when age reaches W+1.
    int             age;
    logic [W-1:0]   pend_res;
    logic [4:0]     pend_dest;
    logic [W-1:0]   exp_result;
    logic [4:0]     exp_dest;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            age        <= 0;
            pend_res   <= '0;
            pend_dest  <= '0;
            exp_result <= '0;
            exp_dest   <= '0;
        end else if (age == 0) begin
            if (bus.start && !bus.kill) begin
                age       <= 1;
                pend_res  <= ref_calc(bus.op, bus.operand_a, bus.operand_b);
                pend_dest <= bus.dest_in;
            end
        end else if (age <= W) begin
            if (bus.kill) begin
                age <= 0;
            end else begin
                age <= age + 1;
                if (age == W) begin
                    exp_result <= pend_res;
                    exp_dest   <= pend_dest;
                end
            end
        end else begin
            age <= 0;
        end
    end

    always @(negedge clk) begin
        if (arst_n) begin
            check("busy",     32'(bus.busy),     32'(age != 0));
            check("done",     32'(bus.done),     32'(age == W + 1));
            check("result",   32'(bus.result),   32'(exp_result));
            check("dest_out", 32'(bus.dest_out), 32'(exp_dest));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] d);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_in   = d;
    endtask

    // Issue one op, wait for done (bounded), check latency/result/dest, return to IDLE.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] d, input logic [W-1:0] exp);
        int n;
        issue(o, a, b, d);
        n = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end while (!bus.done && n < 40);
        check({nm, "_latency"}, 32'(n), 32'd17);
        check({nm, "_result"}, 32'(bus.result), 32'(exp));
        check({nm, "_dest"}, 32'(bus.dest_out), 32'(d));
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        arst_n        = 1'b0;
        bus.start     = 1'b0;
        bus.kill      = 1'b0;
        bus.op        = 2'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy),     32'd0);
        check("rst_done",   32'(bus.done),     32'd0);
        check("rst_result", 32'(bus.result),   32'd0);
        check("rst_dest",   32'(bus.dest_out), 32'd0);
        arst_n = 1'b1;

        do_op("mullo",   2'd0, 16'h1234, 16'h0010, 5'd5,  16'h2340);
        do_op("mulhi",   2'd1, 16'h1234, 16'h0010, 5'd5,  16'h0001);
        do_op("mulhi_ff", 2'd1, 16'hFFFF, 16'hFFFF, 5'd7,  16'hFFFE);
        do_op("mullo_ff", 2'd0, 16'hFFFF, 16'hFFFF, 5'd7,  16'h0001);
        do_op("divu",    2'd2, 16'd100,  16'd7,    5'd3,  16'h000E);
        do_op("remu",    2'd3, 16'd100,  16'd7,    5'd3,  16'h0002);
        do_op("div0",    2'd2, 16'h1234, 16'h0000, 5'd0,  16'hFFFF);
        do_op("rem0",    2'd3, 16'h1234, 16'h0000, 5'd0,  16'h1234);

        // Start pulsed mid-RUN with other operands must be ignored.
        begin
            int n;
            issue(2'd0, 16'h1234, 16'h0010, 5'd5);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 4) begin
                    bus.start     = 1'b1;
                    bus.op        = 2'd3;
                    bus.operand_a = 16'h0005;
                    bus.operand_b = 16'h0003;
                    bus.dest_in   = 5'd9;
                end else begin
                    bus.start = 1'b0;
                end
            end while (!bus.done && n < 40);
            check("ignore_latency", 32'(n), 32'd17);
            check("ignore_result", 32'(bus.result), 32'h2340);
            check("ignore_dest", 32'(bus.dest_out), 32'd5);
            @(negedge clk);
        end

        do_op("rem0_again", 2'd3, 16'h1234, 16'h0000, 5'd2, 16'h1234);

        // Kill sampled while the iteration counter is 5.
        issue(2'd0, 16'h1111, 16'h2222, 5'd9);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n == 6) bus.kill = 1'b1;
            if (n == 7) begin
                bus.kill = 1'b0;
                check("kill_busy", 32'(bus.busy), 32'd0);
            end
        end
        check("kill_result", 32'(bus.result), 32'h1234);
        check("kill_dest", 32'(bus.dest_out), 32'd2);
        do_op("after_kill", 2'd0, 16'h00FF, 16'h0101, 5'd11, 16'hFFFF);

        // Asynchronous reset in the middle of RUN.
        issue(2'd1, 16'hABCD, 16'h1357, 5'd13);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        arst_n = 1'b0;
        #1;
        check("arst_busy",   32'(bus.busy),     32'd0);
        check("arst_done",   32'(bus.done),     32'd0);
        check("arst_result", 32'(bus.result),   32'd0);
        check("arst_dest",   32'(bus.dest_out), 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [4:0]   d;
            o = 2'($urandom_range(0, 3));
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            d = 5'($urandom);
            do_op("rand", o, a, b, d, ref_calc(o, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
